sseg_scan_ctrl: RTL and testbench
=================================

Name: sseg_scan_ctrl

Overview:
Parametrised multi-digit 7-segment display controller. It is the successor to the fixed 4-digit display multiplexer.
- Accepts a binary value through a valid/ready handshake.
- Converts it to BCD with a sequential double-dabble engine and commits the digits atomically.
- Time-multiplexes DIGITS common-anode digits, with leading-zero blanking, decimal points and overflow indication.
- Sits between the DPWM control/measurement logic and the board display pins.

Parameters:
DIGITS, 4, number of display digits (1..8); any value, not only powers of 2.
BIN_W, 10, width of the binary input value (1..27).
PRESC_W, 16, prescaler width; the scan advances one digit every 2^PRESC_W clocks.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
value_in  in  BIN_W  unsigned binary value to display
value_valid  in  1  value_in is valid
value_ready  out  1  block can accept a value
blank_lz  in  1  1 = blank leading zeros (sampled live)
dp_in  in  DIGITS  decimal point request per digit, 1 = on (sampled live)
an  out  DIGITS  digit enables, active-low, one-cold
sseg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point segment, active-low
overflow  out  1  committed value exceeds 10^DIGITS-1

Behaviour:
- Reset values: value_ready=1, overflow=0, display digits all 0, scan index 0, prescaler 0, FSM=IDLE. This gives an=~1 (digit 0 on), sseg=7'b1000000 ("0"), dp=~dp_in[0].
- FSM IDLE: value_ready=1. A transfer occurs when value_valid && value_ready. On transfer, the block:
  - captures value_in into the shift register;
  - sets the overflow candidate to (value_in > 10^DIGITS-1);
  - clears the BCD accumulator;
  - goes to CONV.
- FSM CONV: value_ready=0. Exactly BIN_W cycles. Each cycle adds 3 to every BCD nibble that is >=5, then shifts left 1 with the binary MSB entering.
  - Iteration counter is clog2(BIN_W+1) bits wide.
  - After the last iteration, go to COMMIT.
- FSM COMMIT: one cycle. The lower DIGITS nibbles load into the display register and the overflow output is updated. Then go to IDLE.
- Timing from handshake edge:
  - display register and overflow change BIN_W+1 clocks after the handshake edge;
  - value_ready re-asserts BIN_W+2 clocks after the handshake edge.
- value_valid while busy: ignored. The source must hold it; there is no queuing.
- Scan:
  - The prescaler free-runs modulo 2^PRESC_W.
  - On the prescaler all-ones cycle, the scan index increments; index DIGITS-1 wraps to 0.
  - The index is held in a register. an/sseg/dp are combinational from the index, the display register, blank_lz and dp_in.
- Overflow committed (overflow=1): every digit shows dash (sseg=7'b0111111). Blanking is suppressed; dp_in still applies.
- Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and digits i..DIGITS-1 are all 0. Digit 0 is never blanked.
  - A blanked digit drives an bit=1 (off), sseg=7'h7F, dp=1.
  - This applies even if dp_in requests the point.
- Nibbles >9 cannot occur. If one appears, the default decode is blank (7'h7F).
- Display changes only at COMMIT; a conversion in progress never shows partial digits.
- Reset mid-conversion aborts the conversion: FSM returns to IDLE and the display clears to 0.

Optional Feature:
Macro SSEG_DIM_EN.
- Defined: adds input brightness[3:0]. The active digit's an bit is asserted only while prescaler[PRESC_W-1:PRESC_W-4] < brightness; otherwise all an=1.
  - brightness=0 gives a dark display.
  - brightness=15 gives 15/16 duty.
- Undefined: the port is absent and the active digit is enabled for the full slot.
- Requires PRESC_W>=4.

Decomposition:
- Package sseg_pkg:
  - active-low segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - FSM enum {IDLE, CONV, COMMIT};
  - function seg_decode(nibble).
- Sub-module bin2bcd_seq: the handshake plus double-dabble FSM, outputting bcd[4*DIGITS-1:0], ovf and commit. The top level contains the prescaler, scan index, blanking and output mux.

Test Plan:
- Reset, then value 0 with blank_lz=1 (DIGITS=4, PRESC_W=2) -> only digit 0 ever enabled, sseg=7'b1000000; the other an bits stay 1 across a full scan.
- Send 987 (BIN_W=10) -> value_ready low for 12 cycles. Display commits 11 cycles after the handshake edge. Scan shows 7,8,9 on digits 0..2; digit 3 is blanked (blank_lz=1) or shows "0" (blank_lz=0).
- Send 1023 with DIGITS=3 -> overflow=1 and all three digits show 7'b0111111. Then send 5 -> overflow=0 and "5" is shown.
- Hold value_valid during CONV with a changed value_in -> ignored; the first value commits, then the second is accepted on the first value_ready cycle.
- Assert reset at CONV iteration 4 -> an=~1, sseg="0", value_ready=1 immediately; a fresh value then converts in full.
- DIGITS=3, PRESC_W=2 -> the index sequence is 0,1,2,0, each held 4 clocks. With SSEG_DIM_EN and brightness=0, an stays all 1.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types, segment constants and helpers for the display.
// Segments are {g,f,e,d,c,b,a}, active-low.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] nib
  );
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic int pow10(input int d);
    int r;
    r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: valid/ready capture plus sequential double-dabble converter.
// Ports: clk, reset (async, high), value_in/valid/ready, bcd, ovf, commit.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  commit
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int NW = 4 * DIGITS;
  localparam logic [31:0] MAXV = 32'(pow10(DIGITS) - 1);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [BIN_W-1:0]  sh_q, sh_d;
  logic [NW-1:0]     acc_q, acc_d;
  logic [NW-1:0]     adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // ready drops on the transfer and only comes back one IDLE cycle
  // after COMMIT, so a held request is taken on the first fresh slot.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (ready_q && value_valid) begin
          sh_d    = value_in;
          ovf_d   = 32'(value_in) > MAXV;
          acc_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = CONV;
        end else begin
          ready_d = 1'b1;
        end
      end
      CONV: begin
        acc_d = {adj[NW-2:0], sh_q[BIN_W-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1))
          state_d = COMMIT;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_ready = ready_q;
  assign bcd         = acc_q;
  assign ovf         = ovf_q;
  assign commit      = (state_q == COMMIT);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed common-anode 7-seg driver with BCD conversion.
// Ports: clk, reset, value_*, blank_lz, dp_in, an, sseg, dp, overflow.
// Macro SSEG_DIM_EN adds brightness[3:0] PWM of the active digit.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int BIN_W   = 10,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
`ifdef SSEG_DIM_EN
  input  logic [3:0]         brightness,
`endif
  input  logic [BIN_W-1:0]   value_in,
  input  logic               value_valid,
  output logic               value_ready,
  input  logic               blank_lz,
  input  logic [DIGITS-1:0]  dp_in,
  output logic [DIGITS-1:0]  an,
  output logic [6:0]         sseg,
  output logic               dp,
  output logic               overflow
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = 4 * DIGITS;

  logic [NW-1:0]      bcd;
  logic               ovf_c;
  logic               commit;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NW-1:0]      disp_q, disp_d;
  logic               ovf_q, ovf_d;

  logic [DIGITS-1:0]  lz;
  logic               allz;
  logic [3:0]         nib;
  logic               blank_sel;
  logic               dp_req;
  logic               on;

  bin2bcd_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_conv (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .bcd         (bcd),
    .ovf         (ovf_c),
    .commit      (commit)
  );

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (&presc_q)
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    disp_d  = commit ? bcd : disp_q;
    ovf_d   = commit ? ovf_c : ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  // lz[i]: digit i and everything above it is zero (never for digit 0)
  always_comb begin
    lz   = '0;
    allz = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allz  = allz && (disp_q[4*i +: 4] == 4'd0);
      lz[i] = allz && (i != 0);
    end
  end

  always_comb begin
    nib       = '0;
    blank_sel = 1'b0;
    dp_req    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = disp_q[4*i +: 4];
        blank_sel = blank_lz && !ovf_q && lz[i];
        dp_req    = dp_in[i];
      end
    end
  end

`ifdef SSEG_DIM_EN
  assign on = presc_q[PRESC_W-1 -: 4] < brightness;
`else
  assign on = 1'b1;
`endif

  always_comb begin
    an = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i) && !blank_sel && on)
        an[i] = 1'b0;
    end
    if (blank_sel)  sseg = SEG_BLANK;
    else if (ovf_q) sseg = SEG_DASH;
    else            sseg = seg_decode(nib);
  end

  assign dp       = blank_sel | ~dp_req;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: random + directed bench for two display configurations.
// Checks every cycle against an arithmetic model of value, scan and blanking.
module tb_sseg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] value_in;
  logic       value_valid;
  logic       blank_lz;
  logic [3:0] dp4;
  logic [2:0] dp3;

  logic [3:0] an4;
  logic [6:0] sseg4;
  logic       dpo4, rdy4, ovf4;
  logic [2:0] an3;
  logic [6:0] sseg3;
  logic       dpo3, rdy3, ovf3;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.DIGITS(4), .BIN_W(10), .PRESC_W(2)) u4 (
    .clk(clk), .reset(reset),
    .value_in(value_in), .value_valid(value_valid),
    .value_ready(rdy4), .blank_lz(blank_lz), .dp_in(dp4),
    .an(an4), .sseg(sseg4), .dp(dpo4), .overflow(ovf4)
  );

  sseg_scan_ctrl #(.DIGITS(3), .BIN_W(10), .PRESC_W(2)) u3 (
    .clk(clk), .reset(reset),
    .value_in(value_in), .value_valid(value_valid),
    .value_ready(rdy3), .blank_lz(blank_lz), .dp_in(dp3),
    .an(an3), .sseg(sseg3), .dp(dpo3), .overflow(ovf3)
  );

  localparam logic [6:0] SEGT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  int compared = 0;
  int mismatched = 0;

  // model: edges since reset, accepted value, time of acceptance
  int m_n = 0;
  int m_hs = 0;
  int m_pend = 0;
  int m_disp = 0;
  bit m_busy = 1'b0;
  bit m_hs_flag = 1'b0;
  bit cmp_en = 1'b0;

  function automatic int p10(input int d);
    int r;
    r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] expect_out(
    input int dn, input int n, input int disp,
    input logic blz, input logic [7:0] dpin
  );
    int idx;
    logic ovf, blank, d;
    logic [7:0] a;
    logic [6:0] s;
    idx = (n / 4) % dn;
    ovf = disp > p10(dn) - 1;
    blank = blz && !ovf && idx > 0 && disp < p10(idx);
    a = 8'hFF;
    if (!blank) a[idx] = 1'b0;
    if (blank) s = 7'h7F;
    else if (ovf) s = 7'h3F;
    else s = SEGT[(disp / p10(idx)) % 10];
    d = blank ? 1'b1 : ~dpin[idx];
    return {a, s, d};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_p
    bit rdy;
    if (reset) begin
      m_n = 0;
      m_busy = 1'b0;
      m_disp = 0;
      m_hs_flag = 1'b0;
    end else begin
      rdy = !m_busy;
      m_n++;
      m_hs_flag = 1'b0;
      if (m_busy && m_n == m_hs + 11) m_disp = m_pend;
      if (m_busy && m_n == m_hs + 12) m_busy = 1'b0;
      if (rdy && value_valid) begin
        m_busy = 1'b1;
        m_hs = m_n;
        m_pend = int'(value_in);
        m_hs_flag = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : cmp_p
    int n, d;
    bit busy;
    logic [15:0] e4, e3;
    if (cmp_en) begin
      n = reset ? 0 : m_n;
      d = reset ? 0 : m_disp;
      busy = reset ? 1'b0 : m_busy;
      e4 = expect_out(4, n, d, blank_lz, {4'h0, dp4});
      e3 = expect_out(3, n, d, blank_lz, {5'h0, dp3});
      chk("an4", 32'(an4), 32'(e4[11:8]));
      chk("sseg4", 32'(sseg4), 32'(e4[7:1]));
      chk("dp4", 32'(dpo4), 32'(e4[0]));
      chk("rdy4", 32'(rdy4), 32'(!busy));
      chk("ovf4", 32'(ovf4), 32'(d > 9999));
      chk("an3", 32'(an3), 32'(e3[10:8]));
      chk("sseg3", 32'(sseg3), 32'(e3[7:1]));
      chk("dp3", 32'(dpo3), 32'(e3[0]));
      chk("rdy3", 32'(rdy3), 32'(!busy));
      chk("ovf3", 32'(ovf3), 32'(d > 999));
    end
  end

  // returns 2ns after the accepting edge
  task automatic send(input int v, input bit hold);
    int k;
    @(posedge clk);
    #2;
    value_in = 10'(v);
    value_valid = 1'b1;
    for (k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (m_hs_flag) break;
    end
    chk("send_accept", 32'(m_hs_flag), 32'd1);
    #1;
    if (!hold) value_valid = 1'b0;
  endtask

  task automatic wait_idx(input int dn, input int k);
    int t;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (((m_n / 4) % dn) == k) break;
    end
    chk("wait_idx", 32'(t < 40), 32'd1);
  endtask

  task automatic wait_done();
    repeat (14) @(negedge clk);
  endtask

  initial begin
    int lo, k;
    reset = 1'b1;
    value_in = '0;
    value_valid = 1'b0;
    blank_lz = 1'b0;
    dp4 = '0;
    dp3 = '0;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    @(negedge clk);
    chk("rst_an4", 32'(an4), 32'b1110);
    chk("rst_sseg4", 32'(sseg4), 32'b1000000);
    chk("rst_dp4", 32'(dpo4), 32'd1);
    chk("rst_rdy4", 32'(rdy4), 32'd1);
    chk("rst_ovf3", 32'(ovf3), 32'd0);

    @(posedge clk);
    #2 blank_lz = 1'b1;
    repeat (16) begin
      @(negedge clk);
      chk("lz0_an4", 32'(an4[3:1]), 32'b111);
      chk("lz0_sseg4", 32'(sseg4 & {7{~an4[0]}}),
          32'(7'b1000000 & {7{~an4[0]}}));
    end

    send(987, 1'b0);
    lo = 0;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rdy4) break;
      lo++;
    end
    chk("rdy_low_cycles", 32'(lo), 32'd12);
    wait_idx(4, 0);
    chk("d0_987", 32'(sseg4), 32'b1111000);
    wait_idx(4, 1);
    chk("d1_987", 32'(sseg4), 32'b0000000);
    wait_idx(4, 2);
    chk("d2_987", 32'(sseg4), 32'b0010000);
    wait_idx(4, 3);
    chk("d3_987_blank", 32'(an4), 32'b1111);
    @(posedge clk);
    #2 blank_lz = 1'b0;
    wait_idx(4, 3);
    chk("d3_987_zero_an", 32'(an4), 32'b0111);
    chk("d3_987_zero", 32'(sseg4), 32'b1000000);

    send(1023, 1'b0);
    wait_done();
    chk("ovf3_1023", 32'(ovf3), 32'd1);
    chk("dash3", 32'(sseg3), 32'b0111111);
    chk("ovf4_1023", 32'(ovf4), 32'd0);
    wait_idx(4, 3);
    chk("d3_1023", 32'(sseg4), 32'b1111001);
    send(5, 1'b0);
    wait_done();
    chk("ovf3_5", 32'(ovf3), 32'd0);
    wait_idx(3, 0);
    chk("d0_5", 32'(sseg3), 32'b0010010);

    send(300, 1'b1);
    value_in = 10'd600;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (m_hs_flag) break;
    end
    chk("hold_gap", 32'(k), 32'd12);
    #1 value_valid = 1'b0;
    wait_done();
    wait_idx(4, 2);
    chk("d2_600", 32'(sseg4), 32'b0000010);

    send(777, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(rdy4), 32'd1);
    chk("mid_rst_an", 32'(an4), 32'b1110);
    chk("mid_rst_sseg", 32'(sseg4), 32'b1000000);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    send(42, 1'b0);
    wait_done();
    wait_idx(4, 1);
    chk("d1_42", 32'(sseg4), 32'b0011001);

    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #2;
      value_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0)
        value_in = 10'($urandom_range(990, 1023));
      else
        value_in = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        dp4 = 4'($urandom);
        dp3 = 3'($urandom);
      end
      if (c == 300) reset = 1'b1;
      if (c == 302) reset = 1'b0;
    end
    value_valid = 1'b0;
    repeat (20) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
